conv_stream_ctrl: RTL and testbench

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

---
 rtl/conv_stream_ctrl.sv | 112 +++++++++++
 tb/tb_conv_stream_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// Stream controller wrapping a fixed-latency convolution datapath: admits AXI-Stream beats,
// tracks per-stage validity, and drains the pipeline with zero words at end of frame.
module conv_stream_ctrl #(
    parameter int WORD_WIDTH      = 128,
    parameter int WORDS_PER_IMAGE = 16384,
    parameter int PIPE_LAT        = 10
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [WORD_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  dp_step,
    output logic [WORD_WIDTH-1:0] dp_din,
    input  logic [WORD_WIDTH-1:0] dp_dout,
    output logic                  frame_done,
    output logic                  err_tlast,
    output logic [15:0]           frame_cnt
);

    localparam int CNT_W = (WORDS_PER_IMAGE > 1) ? $clog2(WORDS_PER_IMAGE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_IMAGE - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q;
    logic [PIPE_LAT-1:0] vld_q, vld_d, vld_shift;
    logic [CNT_W-1:0]    in_cnt_q, out_cnt_q;
    logic [15:0]         frame_cnt_q;
    logic                frame_done_q, err_tlast_q;
    logic                out_stall, s_fire, m_fire, flush_step, in_last, out_last;

    assign m_axis_tvalid = vld_q[PIPE_LAT-1];
    assign m_axis_tdata  = dp_dout;
    assign out_last      = (out_cnt_q == LAST_CNT);
    assign in_last       = (in_cnt_q == LAST_CNT);
    assign m_axis_tlast  = m_axis_tvalid & out_last;
    assign out_stall     = m_axis_tvalid & ~m_axis_tready;

    // Gated by reset so upstream never sees ready while the controller is held.
    assign s_axis_tready = s_axis_aresetn & (state_q != FLUSH) & ~out_stall;
    assign s_fire        = s_axis_tvalid & s_axis_tready;
    assign m_fire        = m_axis_tvalid & m_axis_tready;
    assign flush_step    = (state_q == FLUSH) & ~out_stall;
    assign dp_step       = s_fire | flush_step;
    assign dp_din        = (state_q == FLUSH) ? '0 : s_axis_tdata;

    assign frame_done = frame_done_q;
    assign err_tlast  = err_tlast_q;
    assign frame_cnt  = frame_cnt_q;

    generate
        if (PIPE_LAT == 1) begin : g_shift1
            assign vld_shift = s_fire;
        end else begin : g_shiftn
            assign vld_shift = {vld_q[PIPE_LAT-2:0], s_fire};
        end
    endgenerate

    // An output consumed during an input bubble must not be presented again, so its
    // valid bit is dropped even though the datapath itself does not advance.
    always_comb begin
        vld_d = vld_q;
        if (dp_step) begin
            vld_d = vld_shift;
        end else if (m_fire) begin
            vld_d[PIPE_LAT-1] = 1'b0;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q      <= IDLE;
            vld_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            err_tlast_q  <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            frame_done_q <= 1'b0;
            err_tlast_q  <= 1'b0;

            if (s_fire) begin
                in_cnt_q    <= in_last ? '0 : in_cnt_q + 1'b1;
                err_tlast_q <= s_axis_tlast ^ in_last;
            end

            if (m_fire) begin
                out_cnt_q <= out_last ? '0 : out_cnt_q + 1'b1;
                if (out_last) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                end
            end

            // Frame boundaries come from the beat counters; tlast is only checked.
            case (state_q)
                IDLE, RUN: if (s_fire) state_q <= in_last ? FLUSH : RUN;
                FLUSH:     if (m_fire && out_last) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: a small instance (4 words, latency 3) driven from a vector
// table and hand sequences, plus a default-parameter instance run over two full frames.
module tb_conv_stream_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Small instance
    logic        a_v = 1'b0, a_l = 1'b0, a_mr = 1'b1;
    logic [15:0] a_d = '0;
    logic        a_sr, a_mv, a_ml, a_step, a_fd, a_err;
    logic [15:0] a_din, a_dout, a_mdata, a_fc;
    logic [2:0][15:0] dpa_q;

    conv_stream_ctrl #(.WORD_WIDTH(16), .WORDS_PER_IMAGE(4), .PIPE_LAT(3)) u_a (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(a_d), .s_axis_tvalid(a_v), .s_axis_tlast(a_l), .s_axis_tready(a_sr),
        .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mv), .m_axis_tlast(a_ml), .m_axis_tready(a_mr),
        .dp_step(a_step), .dp_din(a_din), .dp_dout(a_dout),
        .frame_done(a_fd), .err_tlast(a_err), .frame_cnt(a_fc)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) dpa_q <= '0;
        else if (a_step) dpa_q <= {dpa_q[1:0], a_din};
    assign a_dout = dpa_q[2];

    // Default-parameter instance
    logic         b_v = 1'b0, b_l = 1'b0, b_mr = 1'b1;
    logic [127:0] b_d = '0;
    logic         b_sr, b_mv, b_ml, b_step, b_fd, b_err;
    logic [127:0] b_din, b_dout, b_mdata;
    logic [15:0]  b_fc;
    logic [9:0][127:0] dpb_q;

    conv_stream_ctrl u_b (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
        .s_axis_tdata(b_d), .s_axis_tvalid(b_v), .s_axis_tlast(b_l), .s_axis_tready(b_sr),
        .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mv), .m_axis_tlast(b_ml), .m_axis_tready(b_mr),
        .dp_step(b_step), .dp_din(b_din), .dp_dout(b_dout),
        .frame_done(b_fd), .err_tlast(b_err), .frame_cnt(b_fc)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) dpb_q <= '0;
        else if (b_step) dpb_q <= {dpb_q[8:0], b_din};
    assign b_dout = dpb_q[9];

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        mr;
        logic        e_sr, e_step, e_mv, e_ml, e_fd, e_err;
        logic [15:0] e_fc, e_din, e_dout;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l, input logic mr,
                                input logic sr, input logic st, input logic mv, input logic ml,
                                input logic fd, input logic er, input logic [15:0] fc,
                                input logic [15:0] din, input logic [15:0] dout);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.mr = mr;
        r.e_sr = sr; r.e_step = st; r.e_mv = mv; r.e_ml = ml; r.e_fd = fd; r.e_err = er;
        r.e_fc = fc; r.e_din = din; r.e_dout = dout;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // One frame of 4 beats at base..base+3; holds m_axis_tready low for stall_len
    // cycles once output is first valid.
    task automatic run_frame(input logic [15:0] base, input int stall_len, input logic [15:0] exp_fc);
        int idx, got, stalls;
        logic done;
        idx = 0; got = 0; stalls = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            a_mr = !(a_mv && stalls < stall_len);
            a_v  = (idx < 4);
            a_d  = base + 16'(idx);
            a_l  = (idx == 3);
            #1;
            if (!a_mr) begin
                chk("bp_step", a_step, 1'b0);
                chk("bp_sready", a_sr, 1'b0);
                chk("bp_hold", a_mdata, base + 16'(got));
                stalls++;
            end
            if (a_v && a_sr) idx++;
            if (a_mv && a_mr) begin
                chk("out_data", a_mdata, base + 16'(got));
                chk("out_last", a_ml, got == 3);
                got++;
                if (got == 4) done = 1'b1;
            end
        end
        chk("out_count", got, 4);
        chk("stall_cycles", stalls, stall_len);
        @(negedge clk);
        a_v = 1'b0; a_mr = 1'b1;
        #1;
        chk("frame_done", a_fd, 1'b1);
        chk("frame_cnt", a_fc, exp_fc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nout, nlast, nbad, beat;

        // Full throughput frame A, then frame B with bubbles and two tlast errors.
        vt[0]  = mk(1, 16'hA000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 16'hA000, 0);
        vt[1]  = mk(1, 16'hA001, 0, 1, 1, 1, 0, 0, 0, 0, 0, 16'hA001, 0);
        vt[2]  = mk(1, 16'hA002, 0, 1, 1, 1, 0, 0, 0, 0, 0, 16'hA002, 0);
        vt[3]  = mk(1, 16'hA003, 1, 1, 1, 1, 1, 0, 0, 0, 0, 16'hA003, 16'hA000);
        vt[4]  = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'hA001);
        vt[5]  = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'hA002);
        vt[6]  = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 16'hA003);
        vt[7]  = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 1, 0, 1, 16'h0000, 0);
        vt[8]  = mk(1, 16'hB000, 0, 1, 1, 1, 0, 0, 0, 0, 1, 16'hB000, 0);
        vt[9]  = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
        vt[10] = mk(1, 16'hB001, 1, 1, 1, 1, 0, 0, 0, 0, 1, 16'hB001, 0);
        vt[11] = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 1, 1, 16'h0000, 0);
        vt[12] = mk(1, 16'hB002, 0, 1, 1, 1, 0, 0, 0, 0, 1, 16'hB002, 0);
        vt[13] = mk(0, 16'h0000, 0, 1, 1, 0, 1, 0, 0, 0, 1, 16'h0000, 16'hB000);
        vt[14] = mk(1, 16'hB003, 0, 1, 1, 1, 0, 0, 0, 0, 1, 16'hB003, 0);
        vt[15] = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 0, 0, 1, 1, 16'h0000, 16'hB001);
        vt[16] = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 0, 0, 0, 1, 16'h0000, 16'hB002);
        vt[17] = mk(0, 16'hFFFF, 0, 1, 0, 1, 1, 1, 0, 0, 1, 16'h0000, 16'hB003);
        vt[18] = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 1, 0, 2, 16'h0000, 0);
        vt[19] = mk(0, 16'h0000, 0, 1, 1, 0, 0, 0, 0, 0, 2, 16'h0000, 0);

        // Reset state, with a valid beat offered.
        a_v = 1'b1; a_d = 16'h1234;
        @(negedge clk); #1;
        chk("rst_sready", a_sr, 1'b0);
        chk("rst_mvalid", a_mv, 1'b0);
        chk("rst_mlast", a_ml, 1'b0);
        chk("rst_step", a_step, 1'b0);
        chk("rst_fcnt", a_fc, 16'd0);
        chk("rst_fdone", a_fd, 1'b0);
        chk("rst_err", a_err, 1'b0);
        @(negedge clk);
        a_v = 1'b0; rst_n = 1'b1;
        #1;
        chk("rel_sready", a_sr, 1'b1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_v = vt[i].v; a_d = vt[i].d; a_l = vt[i].l; a_mr = vt[i].mr;
            #1;
            chk($sformatf("r%0d_sready", i), a_sr, vt[i].e_sr);
            chk($sformatf("r%0d_step", i), a_step, vt[i].e_step);
            chk($sformatf("r%0d_mvalid", i), a_mv, vt[i].e_mv);
            chk($sformatf("r%0d_mlast", i), a_ml, vt[i].e_ml);
            chk($sformatf("r%0d_fdone", i), a_fd, vt[i].e_fd);
            chk($sformatf("r%0d_err", i), a_err, vt[i].e_err);
            chk($sformatf("r%0d_fcnt", i), a_fc, vt[i].e_fc);
            chk($sformatf("r%0d_din", i), a_din, vt[i].e_din);
            if (vt[i].e_mv) chk($sformatf("r%0d_mdata", i), a_mdata, vt[i].e_dout);
        end

        // Backpressure: 5 stalled cycles once output goes valid.
        run_frame(16'hC000, 5, 16'd3);

        // Reset after two accepted beats.
        @(negedge clk);
        a_v = 1'b1; a_d = 16'hE000; a_l = 1'b0; a_mr = 1'b1;
        @(negedge clk);
        a_d = 16'hE001;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sready", a_sr, 1'b0);
        chk("mid_rst_mvalid", a_mv, 1'b0);
        chk("mid_rst_step", a_step, 1'b0);
        chk("mid_rst_fcnt", a_fc, 16'd0);
        @(negedge clk);
        a_v = 1'b0; rst_n = 1'b1;
        nout = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (a_mv) nout++;
        end
        chk("post_rst_outputs", nout, 0);
        run_frame(16'hF000, 0, 16'd1);

        // Default parameters: two back-to-back frames.
        nout = 0; nlast = 0; nbad = 0; beat = 0;
        for (int c = 0; c < 40000 && nout < 32768; c++) begin
            @(negedge clk);
            b_v = (beat < 32768);
            b_d = 128'(beat);
            b_l = ((beat % 16384) == 16383);
            #1;
            if (b_v && b_sr) beat++;
            if (b_mv) begin
                if (b_mdata != 128'(nout)) nbad++;
                if (b_ml) nlast++;
                nout++;
            end
        end
        @(negedge clk);
        b_v = 1'b0;
        #1;
        chk("dflt_outputs", nout, 32768);
        chk("dflt_tlast", nlast, 2);
        chk("dflt_order_errs", nbad, 0);
        chk("dflt_fcnt", b_fc, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
